// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter with TX FIFO on the dmem bus.
// Optional even parity bit: define UART_TX_PARITY_EN.  Rev 1.0
`default_nettype none

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [2:0]  mode,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic       PAR_FLAG = 1'b1;
`else
  localparam logic       PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   div, reload, bit_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  logic        hit, wr_txdata, wr_status, wr_div;
  logic        full, empty, pop, push, busy;
  logic [7:0]  head;
  logic [31:0] count_ext, status;
  logic [3:0]  cnt_nib;
  logic        unused_bits;

  assign hit       = (a[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = we && hit && (a[3:2] == 2'd0);
  assign wr_status = we && hit && (a[3:2] == 2'd1);
  assign wr_div    = we && hit && (a[3:2] == 2'd2);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];
  assign busy  = (state != IDLE);
  // The head leaves the FIFO on the edge that enters START.
  assign pop   = !empty && ((state == IDLE) || ((state == STOP) && (bit_cnt == '0)));
  assign push  = wr_txdata && (!full || pop);

  assign count_ext = 32'(count);
  assign cnt_nib   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status    = {23'b0, PAR_FLAG, cnt_nib, overflow, empty, full, busy};

  assign unused_bits = ^{mode, a[1:0], wd[31:16]};

  always_comb begin
    rd = '0;
    if (hit) begin
      case (a[3:2])
        2'd1:    rd = status;
        2'd2:    rd = {16'b0, div};
        default: rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DIV_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (wr_txdata && full && !pop) overflow <= 1'b1;
      else if (wr_status && wd[3])   overflow <= 1'b0;
      if (wr_div) div <= wd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      reload  <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state   <= START;
            tx      <= 1'b0;
            shreg   <= head;
            reload  <= div;
            bit_cnt <= div;
`ifdef UART_TX_PARITY_EN
            par     <= ^head;
`endif
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_cnt <= reload;
            bit_idx <= '0;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= reload;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_cnt == '0) begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_cnt <= reload;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_cnt == '0) begin
            // Chain straight into the next frame when data is waiting.
            if (!empty) begin
              state   <= START;
              tx      <= 1'b0;
              shreg   <= head;
              reload  <= div;
              bit_cnt <= div;
`ifdef UART_TX_PARITY_EN
              par     <= ^head;
`endif
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx -- scoreboard bench: stimulus queues expected frames, a monitor decodes tx.
// Parity variant selected by UART_TX_PARITY_EN.  Rev 1.0
`default_nettype none

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PB = 32'h100;
  localparam int          FB = 11;
`else
  localparam logic [31:0] PB = 32'h0;
  localparam int          FB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         period;
    int         start;
    bit         gap0;
  } exp_t;

  logic        clk, reset, we, tx;
  logic [31:0] a, wd, rd;
  logic [2:0]  mode;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_end = -10;
  int   frames_started = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd4)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .mode(mode), .rd(rd), .tx(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] m);
    a = addr; wd = data; mode = m; we = 1'b1;
    tick();
    we = 1'b0; a = 32'h0; wd = 32'h0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr; we = 1'b0;
    #1;
    check32(name, rd, exp);
  endtask

  task automatic push_exp(input logic [7:0] d, input int p, input int s, input bit g);
    exp_t e;
    e.data = d; e.period = p; e.start = s; e.gap0 = g;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    a = BASE + 32'h4; we = 1'b0;
    for (k = 0; k < bound; k++) begin
      tick();
      if (rd[0] === 1'b0 && rd[2] === 1'b1) break;
    end
    check32("wait_idle_in_time", 32'(k < bound), 32'd1);
    a = 32'h0;
  endtask

  // Monitor: decode each frame on tx and compare against the scoreboard head.
  task automatic mon_frame(input exp_t e);
    logic [10:0] bits;
    int good;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = e.data;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^e.data;
`endif
    if (e.start >= 0) check32("frame_start_cycle", 32'(cyc), 32'(e.start));
    if (e.gap0) check32("frame_no_gap", 32'(cyc), 32'(last_end + 1));
    for (int b = 0; b < FB; b++) begin
      good = 0;
      for (int c = 0; c < e.period; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (reset === 1'b1) return;
        if (tx === bits[b]) good++;
      end
      check32($sformatf("frame_%02h_bit%0d_samples", e.data, b), 32'(good), 32'(e.period));
    end
    last_end = cyc;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        frames_started++;
        if (sb_q.size() == 0) begin
          check32("unexpected_frame_start", 32'(tx), 32'd1);
          for (int k = 0; k < 5000 && tx !== 1'b1; k++) @(negedge clk);
        end else begin
          e = sb_q.pop_front();
          mon_frame(e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] burst [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                              8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

  initial begin : stimulus
    int fs;
    reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0; mode = 3'b000;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check32("reset_tx", 32'(tx), 32'd1);
    read_check("reset_status", BASE + 32'h4, 32'h4 | PB);
    read_check("reset_bauddiv", BASE + 32'h8, 32'd4);
    tick();
    read_check("txdata_reads_0", BASE, 32'h0);
    read_check("reserved_reads_0", BASE + 32'hC, 32'h0);
    read_check("outside_reads_0", 32'h0000_2004, 32'h0);
    tick();

    // Single byte A5, sb
    push_exp(8'hA5, 5, cyc + 2, 1'b0);
    store(BASE, 32'hFFFF_FFA5, 3'b000);
    read_check("status_after_write", BASE + 32'h4, 32'h10 | PB);
    tick();
    read_check("status_after_pop", BASE + 32'h4, 32'h5 | PB);
    repeat (FB * 5 - 1) tick();
    read_check("busy_last_cycle", BASE + 32'h4, 32'h5 | PB);
    tick();
    read_check("busy_dropped", BASE + 32'h4, 32'h4 | PB);
    tick();

    // Burst of 10 sw stores; 10th dropped
    push_exp(burst[0], 5, cyc + 2, 1'b0);
    for (int i = 1; i < 9; i++) push_exp(burst[i], 5, -1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      a = BASE; wd = {24'hC0FFEE, burst[i]}; mode = 3'b010; we = 1'b1;
      tick();
    end
    we = 1'b0; a = 32'h0;
    read_check("burst_status_overflow", BASE + 32'h4, 32'h8B | PB);
    tick();
    store(BASE + 32'h4, 32'h8, 3'b010);
    read_check("burst_status_cleared", BASE + 32'h4, 32'h83 | PB);
    wait_idle(1000);
    check32("burst_queue_drained", 32'(sb_q.size()), 32'd0);
    tick();

    // BAUDDIV change mid-frame
    push_exp(8'h3C, 5, cyc + 2, 1'b0);
    store(BASE, 32'h3C, 3'b000);
    repeat (10) tick();
    store(BASE + 32'h8, 32'd9, 3'b010);
    read_check("bauddiv_9", BASE + 32'h8, 32'd9);
    tick();
    push_exp(8'hC3, 10, -1, 1'b1);
    store(BASE, 32'hC3, 3'b000);
    wait_idle(1000);
    store(BASE + 32'h8, 32'd4, 3'b010);
    read_check("bauddiv_back_4", BASE + 32'h8, 32'd4);
    tick();

    // Stores to reserved register and outside the window
    fs = frames_started;
    store(BASE + 32'hC, 32'h77, 3'b010);
    store(BASE + 32'h18, 32'h77, 3'b010);
    store(32'h0000_2000, 32'h77, 3'b010);
    repeat (20) tick();
    read_check("ignored_stores_status", BASE + 32'h4, 32'h4 | PB);
    read_check("ignored_stores_bauddiv", BASE + 32'hA, 32'd4);
    check32("ignored_stores_no_frame", 32'(frames_started), 32'(fs));
    tick();

    // Reset during DATA bit 3, with a second byte queued
    push_exp(8'h96, 5, cyc + 2, 1'b0);
    push_exp(8'h69, 5, -1, 1'b1);
    store(BASE, 32'h96, 3'b000);
    store(BASE, 32'h69, 3'b000);
    repeat (21) tick();
    reset = 1'b1;
    tick();
    check32("reset_midframe_tx", 32'(tx), 32'd1);
    read_check("reset_midframe_status", BASE + 32'h4, 32'h4 | PB);
    sb_q.delete();
    reset = 1'b0;
    fs = frames_started;
    repeat (150) tick();
    check32("reset_midframe_no_more_frames", 32'(frames_started), 32'(fs));
    check32("reset_midframe_tx_idle", 32'(tx), 32'd1);

    check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
